// File: rtl/axis_channel_pack_pkg.sv
// Shared helpers for the channel packer: index-width function and tuser flag layout.
package axis_channel_pack_pkg;

  // Number of bits needed to hold values 0..v (at least 1).
  function automatic int log2(input int v);
    int r;
    r = 1;
    while ((1 << r) <= v) r++;
    return r;
  endfunction

  typedef struct packed {
    logic missing_last;
    logic short_group;
  } pack_user_t;

endpackage

// File: rtl/axis_channel_pack_counter.sv
// Bounded up-counter used as the channel index; saturates at UPPER unless WRAP is set.
module axis_channel_pack_counter #(
  parameter int WIDTH = 2,
  parameter int LOWER = 0,
  parameter int UPPER = 3,
  parameter bit WRAP  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= WIDTH'(LOWER);
    end else if (en) begin
      if (count == WIDTH'(UPPER)) count <= WRAP ? WIDTH'(LOWER) : count;
      else                        count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/axis_channel_pack.sv
// Serial-to-parallel AXI-Stream channel packer. Define AXIS_CHANNEL_PACK_TLAST_EN to
// regroup on s_axis_tlast and report short/missing-tlast groups on m_axis_tuser.
module axis_channel_pack
  import axis_channel_pack_pkg::*;
#(
  parameter int  NUM_CHANNELS  = 4,
  parameter int  CHANNEL_WIDTH = 64,
  localparam int DATA_WIDTH    = CHANNEL_WIDTH * NUM_CHANNELS,
  localparam int COUNT_WIDTH   = log2(NUM_CHANNELS - 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [CHANNEL_WIDTH-1:0] s_axis_tdata,
  input  logic                     s_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [1:0]               m_axis_tuser
);

  localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(NUM_CHANNELS - 1);

  logic [COUNT_WIDTH-1:0]                        count;
  logic [NUM_CHANNELS-1:0][CHANNEL_WIDTH-1:0]    lanes;
  logic [NUM_CHANNELS-1:0][CHANNEL_WIDTH-1:0]    packed_word;
  logic                                          accept, complete, at_last;
  pack_user_t                                    user_next;

  assign accept  = s_axis_tvalid & s_axis_tready;
  assign at_last = (count == LAST_IDX);

`ifdef AXIS_CHANNEL_PACK_TLAST_EN
  // Early tlast is only visible with the beat, so stall everything while blocked.
  assign s_axis_tready          = ~m_axis_tvalid | m_axis_tready;
  assign complete               = accept & (at_last | s_axis_tlast);
  assign user_next.short_group  = s_axis_tlast & ~at_last;
  assign user_next.missing_last = at_last & ~s_axis_tlast;
`else
  logic unused_tlast;
  assign unused_tlast  = s_axis_tlast;
  assign s_axis_tready = ~at_last | ~m_axis_tvalid | m_axis_tready;
  assign complete      = accept & at_last;
  assign user_next     = '0;
`endif

  axis_channel_pack_counter #(
    .WIDTH (COUNT_WIDTH),
    .LOWER (0),
    .UPPER (NUM_CHANNELS - 1),
    .WRAP  (1'b0)
  ) u_count (
    .clk   (clk),
    .rst   (rst | complete),
    .en    (accept),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst | complete) lanes <= '0;
    else if (accept)    lanes[count] <= s_axis_tdata;
  end

  // Word as it will be loaded on a completing beat: incoming word in lane `count`, zeros above.
  always_comb begin
    packed_word = lanes;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (COUNT_WIDTH'(i) == count)     packed_word[i] = s_axis_tdata;
      else if (COUNT_WIDTH'(i) > count) packed_word[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
    end else if (complete) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= packed_word;
      m_axis_tuser  <= user_next;
    end else if (m_axis_tvalid & m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_channel_pack.sv
// Directed bench for axis_channel_pack with a queue-based group model and per-cycle compare.
module tb_axis_channel_pack;
  localparam int N  = 4;
  localparam int CW = 64;
  localparam int DW = N * CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_tvalid, s_tready, s_tlast;
  logic [CW-1:0] s_tdata;
  logic          m_tvalid, m_tready;
  logic [DW-1:0] m_tdata;
  logic [1:0]    m_tuser;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  axis_channel_pack #(.NUM_CHANNELS(N), .CHANNEL_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] pack4(logic [CW-1:0] c0, logic [CW-1:0] c1,
                                          logic [CW-1:0] c2, logic [CW-1:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  // Model: words of the open group in a queue; a finished group becomes the expected output.
  logic [CW-1:0] part[$];
  logic [DW-1:0] exp_word;
  logic [1:0]    exp_user;
  bit            m_full = 1'b0;
  bit            rst_seen = 1'b0;
  bit            mlast;

  always @(posedge clk) begin
    rst_seen = rst;
    if (rst) begin
      part.delete();
      m_full   = 1'b0;
      exp_word = '0;
      exp_user = '0;
    end else begin
      if (m_full && m_tready) m_full = 1'b0;
      if (s_tvalid && s_tready) begin
        mlast = 1'b0;
`ifdef AXIS_CHANNEL_PACK_TLAST_EN
        mlast = s_tlast;
`endif
        part.push_back(s_tdata);
        if (part.size() == N || mlast) begin
          exp_word = '0;
          foreach (part[i]) exp_word[i*CW +: CW] = part[i];
          exp_user = '0;
`ifdef AXIS_CHANNEL_PACK_TLAST_EN
          exp_user = {part.size() == N && !mlast, part.size() < N && mlast};
`endif
          m_full = 1'b1;
          part.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && rst_seen) begin
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tdata", m_tdata, 0);
      chk("rst_tuser", m_tuser, 0);
      chk("rst_s_tready", s_tready, 1);
    end else if (!rst) begin
      chk("m_tvalid", m_tvalid, m_full);
      if (m_full) begin
        chk("m_tdata", m_tdata, exp_word);
        chk("m_tuser", m_tuser, exp_user);
      end
`ifdef AXIS_CHANNEL_PACK_TLAST_EN
      chk("s_tready", s_tready, !m_full || m_tready);
`else
      chk("s_tready", s_tready, part.size() != N - 1 || !m_full || m_tready);
`endif
    end
  end

  task automatic send(input logic [CW-1:0] d, input logic l);
    int w;
    w = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    @(negedge clk);
    while (!s_tready && w < 50) begin
      w++;
      @(negedge clk);
    end
    chk("send_wait_bound", w < 50, 1);
    @(posedge clk);
    #1 s_tvalid = 1'b0;
  endtask

  initial begin
    int t0;
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Continuous stream, two groups, no stall
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      send(CW'(16 + i), 1'b0);
      if (i == 3) begin
        chk("t1_valid0", m_tvalid, 1);
        chk("t1_word0", m_tdata, pack4(64'h10, 64'h11, 64'h12, 64'h13));
      end
    end
    chk("t1_valid1", m_tvalid, 1);
    chk("t1_word1", m_tdata, pack4(64'h14, 64'h15, 64'h16, 64'h17));
    chk("t1_cycles", cyc - t0, 8);

    // Output blocked: stall, hold, then release with a simultaneous accept/complete
    m_tready = 1'b0;
`ifndef AXIS_CHANNEL_PACK_TLAST_EN
    send(64'h20, 1'b0); send(64'h21, 1'b0); send(64'h22, 1'b0);
    s_tvalid = 1'b1; s_tdata = 64'h23; s_tlast = 1'b0;
`else
    s_tvalid = 1'b1; s_tdata = 64'h20; s_tlast = 1'b0;
`endif
    repeat (10) begin
      @(negedge clk);
      chk("t2_stall", s_tready, 0);
      chk("t2_hold", m_tdata, pack4(64'h14, 64'h15, 64'h16, 64'h17));
    end
    @(posedge clk);
    #1 m_tready = 1'b1;
    @(posedge clk);
    #1 s_tvalid = 1'b0;
`ifdef AXIS_CHANNEL_PACK_TLAST_EN
    send(64'h21, 1'b0); send(64'h22, 1'b0); send(64'h23, 1'b0);
`endif
    chk("t3_valid", m_tvalid, 1);
    chk("t3_word", m_tdata, pack4(64'h20, 64'h21, 64'h22, 64'h23));
    for (int i = 0; i < 4; i++) send(CW'(36 + i), 1'b0);
    chk("t2_next", m_tdata, pack4(64'h24, 64'h25, 64'h26, 64'h27));

    // Reset mid-group, with a pending output where the configuration allows it
`ifndef AXIS_CHANNEL_PACK_TLAST_EN
    m_tready = 1'b0;
`endif
    send(64'h30, 1'b0); send(64'h31, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; m_tready = 1'b1;
    chk("t4_valid_after_rst", m_tvalid, 0);
    for (int i = 0; i < 4; i++) send(CW'(64 + i), 1'b0);
    chk("t4_word", m_tdata, pack4(64'h40, 64'h41, 64'h42, 64'h43));

`ifdef AXIS_CHANNEL_PACK_TLAST_EN
    send(64'hA, 1'b0); send(64'hB, 1'b1);
    chk("t5_short_word", m_tdata, pack4(64'hA, 64'hB, 64'h0, 64'h0));
    chk("t5_short_user", m_tuser, 2'b01);
    send(64'hC, 1'b0); send(64'hD, 1'b0); send(64'hE, 1'b0); send(64'hF, 1'b0);
    chk("t6_miss_word", m_tdata, pack4(64'hC, 64'hD, 64'hE, 64'hF));
    chk("t6_miss_user", m_tuser, 2'b10);
    send(64'h1, 1'b0); send(64'h2, 1'b0); send(64'h3, 1'b0); send(64'h4, 1'b1);
    chk("t6_clean_word", m_tdata, pack4(64'h1, 64'h2, 64'h3, 64'h4));
    chk("t6_clean_user", m_tuser, 2'b00);
`else
    send(64'h50, 1'b0); send(64'h51, 1'b1); send(64'h52, 1'b0); send(64'h53, 1'b0);
    chk("t5_tlast_ignored", m_tdata, pack4(64'h50, 64'h51, 64'h52, 64'h53));
    chk("t5_user_zero", m_tuser, 2'b00);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axis_channel_pack.md
# axis_channel_pack

Serial-to-parallel channel packer for the peak-detection datapath. It accepts one CHANNEL_WIDTH word per AXI-Stream beat in channel order 0..NUM_CHANNELS-1 and assembles each group into one DATA_WIDTH bus word. That bus word is emitted on a registered master interface. It is the inverse of the per-channel serialization used ahead of the complex-magnitude units, and it rebuilds the multi-channel bus after per-channel processing.

## Interface
- NUM_CHANNELS, 4: channels per output bus word; must be ≥ 2.
- CHANNEL_WIDTH, 64: bits per channel word.
- DATA_WIDTH (derived): CHANNEL_WIDTH * NUM_CHANNELS.
- COUNT_WIDTH (derived): log2(NUM_CHANNELS - 1).
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high together with tvalid.
- s_axis_tdata  in  CHANNEL_WIDTH  one channel word.
- s_axis_tlast  in  1  marks the last channel of a group. Used only with TLAST_EN.
- m_axis_tvalid  out  1  packed word valid.
- m_axis_tready  in  1  downstream accept.
- m_axis_tdata  out  DATA_WIDTH  packed word; channel n is in bits [n*CHANNEL_WIDTH +: CHANNEL_WIDTH].
- m_axis_tuser  out  2  bit0 = short group (zero-padded), bit1 = missing tlast. Both bits are 0 without TLAST_EN.

## Operation
- Channel counter `count` runs 0..NUM_CHANNELS-1. It advances only on an accepted input beat (s_axis_tvalid & s_axis_tready).
- Each accepted word is written to assembly lane `count`.
- A completing beat is an accepted beat with count == NUM_CHANNELS-1, or, with TLAST_EN, an accepted beat with tlast=1.
- On a completing beat, on the same edge:
  - Load the output register with the assembly lanes, including the word arriving on that beat.
  - Lanes above the completing index are loaded as zero.
  - Set m_axis_tvalid.
  - Reset count to 0 and clear the assembly lanes.
- Output register update rule:
  - Hold value while m_axis_tvalid & ~m_axis_tready.
  - On (m_axis_tvalid & m_axis_tready) with no completing beat: clear m_axis_tvalid. tdata and tuser keep their stale values.
- s_axis_tready:
  - Without TLAST_EN: (count != NUM_CHANNELS-1) | ~m_axis_tvalid | m_axis_tready. Non-final beats are never stalled.
  - With TLAST_EN: ~m_axis_tvalid | m_axis_tready. The early tlast cannot be known in advance, so every beat is stalled while the output is blocked.
  - s_axis_tready never depends on s_axis_tdata or s_axis_tlast.
- m_axis_tuser, with TLAST_EN only:
  - bit0 = 1 when the group closed early (tlast at count < NUM_CHANNELS-1).
  - bit1 = 1 when the final beat (count == NUM_CHANNELS-1) arrived with tlast=0. The group is still emitted and count wraps to 0.
- Throughput: one packed word every NUM_CHANNELS input cycles, with no bubbles under continuous valid/ready.

## Timing
- Latency: a completing beat accepted at edge k gives m_axis_tvalid=1 in the cycle after edge k.
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, count=0, assembly lanes=0.
- Reset state of s_axis_tready: 1.
- rst mid-group discards the partial group.
- rst while m_axis_tvalid=1 drops the pending word.
- Simultaneous output accept and completing beat: the new word replaces the old one on the same edge, and m_axis_tvalid stays 1.
- Full condition (without TLAST_EN): count == NUM_CHANNELS-1, m_axis_tvalid=1 and m_axis_tready=0. Then s_axis_tready=0.
- No empty condition on the input side: the block never produces an output without a completing beat.

## Configuration
- AXIS_CHANNEL_PACK_TLAST_EN defined:
  - s_axis_tlast resynchronizes grouping.
  - m_axis_tuser flags are generated.
  - s_axis_tready uses the conservative form.
- AXIS_CHANNEL_PACK_TLAST_EN undefined:
  - s_axis_tlast is ignored.
  - m_axis_tuser is tied to 0.
  - Grouping is purely by count.
  - s_axis_tready uses the non-stalling form.

## Structure
- COUNT_WIDTH comes from the shared log2 function header, the same as every other peak-path block.
- No block-specific shared constants are needed.
- One sub-module: the existing `counter` for the channel index, with LOWER 0, UPPER NUM_CHANNELS-1 and no wraparound.
  - Its enable is the accepted beat.
  - Its reset is rst | completing beat.
- Assembly lanes and the output register are local always blocks.

## Test plan
- Continuous stream with NUM_CHANNELS=4, words 0x10..0x17, m_axis_tready=1 -> two outputs, {0x13,0x12,0x11,0x10} then {0x17,0x16,0x15,0x14}, each valid one cycle after the 4th beat, with no input stall.
- m_axis_tready=0 for 10 cycles with the output full -> s_axis_tready drops at count==3 and m_axis_tdata holds. After release, the next group follows without loss or duplication.
- Output accept and a completing beat on the same edge -> m_axis_tvalid stays high and the new word appears the next cycle.
- rst asserted after 2 beats of a group -> the next 4 beats form a clean group starting at lane 0, and all outputs read 0 during reset.
- TLAST_EN: tlast on the 2nd beat (0xA,0xB) -> output {0,0,0xB,0xA} with tuser=01. The next group starts at lane 0.
- TLAST_EN: 4 beats without tlast -> word emitted with tuser=10 and count wraps to 0.
